msrv32_muldiv_unit: RTL

- Iterative RV32M multiply/divide unit in the execute stage.
- Consumes the registered operands, rd address and funct3 from the decode/execute pipeline register, alongside the ALU.
- Holds the pipeline via busy_out for the whole operation, then presents one result to the writeback mux with a single-cycle done pulse.
- Radix-2: one partial product or one restoring-divide step per cycle.

---
 rtl/msrv32_muldiv_pkg.sv | 24 ++
 rtl/msrv32_muldiv_sign_ctrl.sv | 65 ++++++
 rtl/msrv32_muldiv_unit.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/msrv32_muldiv_pkg.sv
// Shared constants for the RV32M iterative multiply/divide unit.
// Holds the funct3 operation codes, the FSM state encoding and the
// special-case result constants used by the top and the sign controller.
package msrv32_muldiv_pkg;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam logic [31:0] DIV0_QUOT = 32'hFFFF_FFFF;
  localparam logic [31:0] INT_MIN   = 32'h8000_0000;

endpackage

// File: rtl/msrv32_muldiv_sign_ctrl.sv
// Sign handling for the multiply/divide unit (purely combinational).
// The datapath works on magnitudes only; this block produces them and
// restores the sign of the finished result.
//   op, rs1, rs2    : operation and raw operands at the accept edge
//   abs_a, abs_b    : operand magnitudes (signed operands only negated)
//   neg_res         : result must be negated at the end
//   fin_op, fin_neg : operation and sign flag captured at accept
//   prod, quot, rem : unsigned datapath results of the final step
//   result          : sign-corrected, op-selected 32-bit result
module msrv32_muldiv_sign_ctrl
  import msrv32_muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]        op,
  input  logic [XLEN-1:0]   rs1,
  input  logic [XLEN-1:0]   rs2,
  output logic [XLEN-1:0]   abs_a,
  output logic [XLEN-1:0]   abs_b,
  output logic              neg_res,
  input  logic [2:0]        fin_op,
  input  logic              fin_neg,
  input  logic [2*XLEN-1:0] prod,
  input  logic [XLEN-1:0]   quot,
  input  logic [XLEN-1:0]   rem,
  output logic [XLEN-1:0]   result
);

  logic              signed_a;
  logic              signed_b;
  logic              neg_a;
  logic              neg_b;
  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   quot_s;
  logic [XLEN-1:0]   rem_s;

  always_comb begin
    // MULHSU treats only rs1 as signed; the U variants neither.
    signed_a = (op != OP_MULHU) && (op != OP_DIVU) && (op != OP_REMU);
    signed_b = (op == OP_MUL) || (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    neg_a    = signed_a & rs1[XLEN-1];
    neg_b    = signed_b & rs2[XLEN-1];
    // INT_MIN negates to itself, which is its correct unsigned magnitude.
    abs_a    = neg_a ? -rs1 : rs1;
    abs_b    = neg_b ? -rs2 : rs2;
    // Remainder follows the dividend; products and quotients follow a ^ b.
    neg_res  = (op == OP_REM) ? neg_a : (neg_a ^ neg_b);
  end

  always_comb begin
    // NOTE: every output of a combinational block gets a value on every path
    // (here: default first), otherwise synthesis infers a latch.
    result = '0;
    prod_s = fin_neg ? -prod : prod;
    quot_s = fin_neg ? -quot : quot;
    rem_s  = fin_neg ? -rem  : rem;
    case (fin_op)
      OP_MUL:                     result = prod_s[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: result = prod_s[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:            result = quot_s;
      default:                    result = rem_s;
    endcase
  end

endmodule

// File: rtl/msrv32_muldiv_unit.sv
// Iterative radix-2 RV32M multiply/divide unit for the execute stage.
// One shift-add multiply step or one restoring-divide step per cycle;
// busy_out stalls the pipeline from accept until the done cycle ends.
//   clk_in, reset_in : clock, synchronous active-high reset
//   start_in, kill_in: request (IDLE only) and flush/abort
//   op_in            : funct3 (MUL..REMU)
//   rs1_in, rs2_in   : operands; rd_addr_in destination register
//   busy_out         : stall request (state != IDLE)
//   done_out         : one-cycle result valid
//   result_out       : result; rd_addr_out destination captured at accept
// Optional build macro MSRV32_MULDIV_EARLY_OUT_EN: divide-by-zero, signed
// overflow and multiply-by-zero go straight from accept to DONE.
module msrv32_muldiv_unit
  import msrv32_muldiv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk_in,
  input  logic            reset_in,
  input  logic            start_in,
  input  logic            kill_in,
  input  logic [2:0]      op_in,
  input  logic [XLEN-1:0] rs1_in,
  input  logic [XLEN-1:0] rs2_in,
  input  logic [4:0]      rd_addr_in,
  output logic            busy_out,
  output logic            done_out,
  output logic [XLEN-1:0] result_out,
  output logic [4:0]      rd_addr_out
);

  state_t            state, state_nx;
  logic [CNT_W-1:0]  cnt;
  logic [2:0]        op_q;
  logic              neg_q;
  logic              spec_hit_q;
  logic [XLEN-1:0]   spec_val_q;
  logic [XLEN-1:0]   a_q;       // |A|: multiplicand
  logic [XLEN-1:0]   b_q;       // |B|: divisor
  logic [2*XLEN-1:0] prod_q;    // high: running sum, low: multiplier being shifted out
  logic [XLEN-1:0]   rem_q;     // stored remainder is always < divisor
  logic [XLEN-1:0]   quot_q;    // dividend shifted out / quotient shifted in

  logic              accept, last, early_hit;
  logic              div0, ovf, spec_hit;
  logic [XLEN-1:0]   spec_val;
  logic [XLEN-1:0]   abs_a, abs_b, fin_result;
  logic              neg_res;
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] prod_nx;
  logic [XLEN:0]     part_rem;  // 33-bit partial remainder of this step
  logic [XLEN:0]     trial;
  logic [XLEN-1:0]   rem_nx, quot_nx;

  msrv32_muldiv_sign_ctrl #(.XLEN(XLEN)) u_sign_ctrl (
    .op      (op_in),
    .rs1     (rs1_in),
    .rs2     (rs2_in),
    .abs_a   (abs_a),
    .abs_b   (abs_b),
    .neg_res (neg_res),
    .fin_op  (op_q),
    .fin_neg (neg_q),
    .prod    (prod_nx),
    .quot    (quot_nx),
    .rem     (rem_nx),
    .result  (fin_result)
  );

  assign accept = (state == IDLE) && start_in && !kill_in;
  assign last   = (cnt == CNT_W'(XLEN - 1));

  // Special-case detection on the raw operands at the accept edge.
  always_comb begin
    div0     = op_in[2] && (rs2_in == '0);
    ovf      = ((op_in == OP_DIV) || (op_in == OP_REM)) &&
               (rs1_in == INT_MIN) && (rs2_in == '1);
    spec_hit = div0 || ovf;
    spec_val = '0;
    if (div0)     spec_val = op_in[1] ? rs1_in : DIV0_QUOT;
    else if (ovf) spec_val = op_in[1] ? '0 : INT_MIN;
  end

`ifdef MSRV32_MULDIV_EARLY_OUT_EN
  logic mul_zero;
  assign mul_zero  = !op_in[2] && ((rs1_in == '0) || (rs2_in == '0));
  assign early_hit = spec_hit || mul_zero;
`else
  assign early_hit = 1'b0;
`endif

  // One radix-2 step of each datapath, evaluated every cycle.
  always_comb begin
    mul_sum  = {1'b0, prod_q[2*XLEN-1:XLEN]} + {1'b0, (prod_q[0] ? a_q : '0)};
    prod_nx  = {mul_sum, prod_q[XLEN-1:1]};
    part_rem = {rem_q, quot_q[XLEN-1]};
    // part_rem < 2*divisor, so bit XLEN of the difference is the borrow.
    trial    = part_rem - {1'b0, b_q};
    rem_nx   = trial[XLEN] ? part_rem[XLEN-1:0] : trial[XLEN-1:0];
    quot_nx  = {quot_q[XLEN-2:0], !trial[XLEN]};
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = early_hit ? DONE : CALC;
      CALC:    if (kill_in) state_nx = IDLE;
               else if (last) state_nx = DONE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    // NOTE: sequential state is written with non-blocking assignments so all
    // flops sample pre-edge values and simulation order cannot matter.
    if (reset_in) state <= IDLE;
    else          state <= state_nx;
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      cnt         <= '0;
      op_q        <= '0;
      neg_q       <= 1'b0;
      spec_hit_q  <= 1'b0;
      spec_val_q  <= '0;
      a_q         <= '0;
      b_q         <= '0;
      prod_q      <= '0;
      rem_q       <= '0;
      quot_q      <= '0;
      result_out  <= '0;
      rd_addr_out <= '0;
    end else if (accept) begin
      cnt         <= '0;
      op_q        <= op_in;
      neg_q       <= neg_res;
      spec_hit_q  <= spec_hit;
      spec_val_q  <= spec_val;
      a_q         <= abs_a;
      b_q         <= abs_b;
      prod_q      <= {{XLEN{1'b0}}, abs_b};
      rem_q       <= '0;
      quot_q      <= abs_a;
      rd_addr_out <= rd_addr_in;
      if (early_hit) result_out <= spec_val;
    end else if ((state == CALC) && !kill_in) begin
      cnt    <= cnt + CNT_W'(1);
      prod_q <= prod_nx;
      rem_q  <= rem_nx;
      quot_q <= quot_nx;
      if (last) result_out <= spec_hit_q ? spec_val_q : fin_result;
    end
  end

  assign busy_out = (state != IDLE);
  assign done_out = (state == DONE) && !kill_in && !reset_in;

endmodule
